// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf output packetizer: BFT packet layout and credit limits.
package leaf_pkg;

    localparam int VALID_BIT = 48;
    localparam int LEAF_MSB  = 47;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_MSB  = 42;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_MSB  = 38;
    localparam int ADDR_LSB  = 32;

    // Credit after reset equals the destination BRAM depth and is also the saturation ceiling.
    localparam int CREDIT_INIT = 128;

    typedef struct packed {
        logic        valid;
        logic [4:0]  leaf;
        logic [3:0]  port;
        logic [6:0]  addr;
        logic [31:0] payload;
    } packet_t;

endpackage

// File: rtl/leaf_out_packetizer_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping at N-1.
module rr_arbiter #(
    parameter int N     = 7,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        pos     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(N)) begin
                pos = pos - (IDX_W+1)'(N);
            end
            idx = pos[IDX_W-1:0];
            if (en && !gnt_vld && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_out_packetizer.sv
// Leaf shell output stage: round-robin over user output streams, credit gating,
// and stamping of destination leaf/port and BRAM write address onto each BFT packet.
module leaf_out_packetizer
    import leaf_pkg::*;
#(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int NUM_OUT_PORTS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int CREDIT_INIT           = leaf_pkg::CREDIT_INIT
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    input  logic                                  cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]              cfg_stream,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_port,
    input  logic                                  fs_upd,
    input  logic [NUM_PORT_BITS-1:0]              fs_stream,
    output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
    input  logic                                  out_ready
);

    localparam int SEL_W    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CREDIT_W = NUM_ADDR_BITS + 1;

    logic [NUM_OUT_PORTS-1:0] cfg_valid;
    logic [NUM_LEAF_BITS-1:0] cfg_leaf_q [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] cfg_port_q [NUM_OUT_PORTS];
    logic [CREDIT_W-1:0]      credit_q   [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] addr_q     [NUM_OUT_PORTS];
    logic [PAYLOAD_BITS-1:0]  payload    [NUM_OUT_PORTS];
    logic [SEL_W-1:0]         rr_ptr;
    packet_t                  dout_q;

    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] gnt;
    logic [SEL_W-1:0]         gnt_idx;
    logic                     gnt_vld;
    logic                     slot_free;

    // Credit after an optional freespace return and an optional grant, clamped at the BRAM depth.
    function automatic logic [CREDIT_W-1:0] next_credit(
        input logic [CREDIT_W-1:0] cur,
        input logic                add,
        input logic                take
    );
        logic [CREDIT_W:0] sum;
        sum = {1'b0, cur};
        if (add) begin
            sum = sum + (CREDIT_W+1)'(FREESPACE_UPDATE_SIZE);
        end
        if (take) begin
            sum = sum - 1'b1;
        end
        if (sum > (CREDIT_W+1)'(CREDIT_INIT)) begin
            sum = (CREDIT_W+1)'(CREDIT_INIT);
        end
        return sum[CREDIT_W-1:0];
    endfunction

    assign slot_free = !dout_q.valid || out_ready;

    // A stream being (re)configured this cycle sits out so its address reset cannot collide with a grant.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            payload[i]  = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            eligible[i] = vld_user2interface[i] && cfg_valid[i] && (credit_q[i] != '0)
                          && !(cfg_wr && (cfg_stream == NUM_PORT_BITS'(i)));
        end
    end

    rr_arbiter #(
        .N     (NUM_OUT_PORTS),
        .IDX_W (SEL_W)
    ) u_rr_arbiter (
        .req     (eligible),
        .ptr     (rr_ptr),
        .en      (slot_free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign ack_interface2user      = gnt;
    assign dout_leaf_interface2bft = dout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q    <= '0;
            cfg_valid <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                cfg_leaf_q[i] <= '0;
                cfg_port_q[i] <= '0;
                credit_q[i]   <= CREDIT_W'(CREDIT_INIT);
                addr_q[i]     <= '0;
            end
        end else begin
            if (gnt_vld) begin
                dout_q.valid    <= 1'b1;
                dout_q.leaf     <= cfg_leaf_q[gnt_idx];
                dout_q.port     <= cfg_port_q[gnt_idx];
                dout_q.addr     <= addr_q[gnt_idx];
                dout_q.payload  <= payload[gnt_idx];
                addr_q[gnt_idx] <= addr_q[gnt_idx] + 1'b1;
                rr_ptr          <= (gnt_idx == SEL_W'(NUM_OUT_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (slot_free) begin
                dout_q.valid <= 1'b0;
            end
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= next_credit(credit_q[i],
                                           fs_upd && (fs_stream == NUM_PORT_BITS'(i)),
                                           gnt[i]);
                if (cfg_wr && (cfg_stream == NUM_PORT_BITS'(i))) begin
                    cfg_valid[i]  <= 1'b1;
                    cfg_leaf_q[i] <= cfg_leaf;
                    cfg_port_q[i] <= cfg_port;
                    addr_q[i]     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Scoreboard bench for leaf_out_packetizer: directed streams push hand-computed packets,
// an independent monitor pops them whenever the DUT hands a packet downstream.
module tb_leaf_out_packetizer;

    localparam int N = 7;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*32-1:0] din;
    logic [N-1:0]    vld;
    logic [N-1:0]    ack;
    logic            cfg_wr;
    logic [3:0]      cfg_stream;
    logic [4:0]      cfg_leaf;
    logic [3:0]      cfg_port;
    logic            fs_upd;
    logic [3:0]      fs_stream;
    logic [48:0]     dout;
    logic            out_ready;

    logic [48:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    leaf_out_packetizer dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .cfg_wr                  (cfg_wr),
        .cfg_stream              (cfg_stream),
        .cfg_leaf                (cfg_leaf),
        .cfg_port                (cfg_port),
        .fs_upd                  (fs_upd),
        .fs_stream               (fs_stream),
        .dout_leaf_interface2bft (dout),
        .out_ready               (out_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [48:0] pkt(input logic [4:0] l, input logic [3:0] p,
                                        input logic [6:0] a, input logic [31:0] d);
        return {1'b1, l, p, a, d};
    endfunction

    // Monitor: a packet is consumed at the edge following a cycle with valid and out_ready.
    initial begin
        logic [48:0] e;
        forever begin
            @(negedge clk);
            if (dout[48] === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL pkt_unexpected: got %h, expected none", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("pkt", {15'b0, dout}, {15'b0, e});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_payload(input int s, input logic [31:0] p);
        din[s*32 +: 32] = p;
    endtask

    task automatic do_reset();
        reset = 1'b1; vld = '0; cfg_wr = 1'b0; fs_upd = 1'b0; out_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic configure(input int s, input int l, input int p);
        cfg_wr = 1'b1; cfg_stream = 4'(s); cfg_leaf = 5'(l); cfg_port = 4'(p);
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic fs_pulse(input int s);
        fs_upd = 1'b1; fs_stream = 4'(s);
        step();
        fs_upd = 1'b0;
    endtask

    task automatic send(input int s, input int n, input logic [31:0] base,
                        input int l, input int p, input int a0);
        for (int k = 0; k < n; k++) begin
            vld = '0; vld[s] = 1'b1;
            set_payload(s, base + 32'(k));
            #1;
            chk("ack_send", 64'(ack), 64'(1) << s);
            exp_q.push_back(pkt(5'(l), 4'(p), 7'(a0 + k), base + 32'(k)));
            step();
        end
        vld = '0;
    endtask

    task automatic expect_block(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            vld = '0; vld[s] = 1'b1;
            #1;
            chk("ack_blocked", 64'(ack), 64'(0));
            step();
        end
        vld = '0;
    endtask

    initial begin
        logic [48:0] held;
        din = '0; vld = '0; cfg_wr = 1'b0; cfg_stream = '0; cfg_leaf = '0; cfg_port = '0;
        fs_upd = 1'b0; fs_stream = '0; out_ready = 1'b1; reset = 1'b1;

        // Reset state, with user valids high throughout
        vld = '1;
        step();
        step();
        chk("reset_dout", 64'(dout), 64'(0));
        chk("reset_ack", 64'(ack), 64'(0));
        reset = 1'b0;
        step();
        chk("unconfigured_ack", 64'(ack), 64'(0));
        vld = '0;

        // Single stream: no ack in the configuration cycle, then addr 0 and addr 1
        cfg_wr = 1'b1; cfg_stream = 4'd0; cfg_leaf = 5'd3; cfg_port = 4'd2;
        vld[0] = 1'b1; set_payload(0, 32'hDEADBEEF);
        #1;
        chk("ack_cfg_cycle", 64'(ack), 64'(0));
        step();
        cfg_wr = 1'b0;
        send(0, 2, 32'hDEADBEEF, 3, 2, 0);

        // Ignored configuration to an out-of-range stream must not disturb stream 0
        configure(9, 31, 15);
        send(0, 1, 32'h0000_0A0A, 3, 2, 2);

        // Round robin across all streams from pointer 0
        do_reset();
        for (int i = 0; i < N; i++) configure(i, 10 + i, i);
        vld = '1;
        for (int i = 0; i < N; i++) set_payload(i, 32'hC0DE_0000 + 32'(i));
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("ack_rr", 64'(ack), 64'(1) << (k % N));
            exp_q.push_back(pkt(5'(10 + k % N), 4'(k % N), 7'(k / N), 32'hC0DE_0000 + 32'(k % N)));
            step();
        end
        vld = '0;

        // Credit exhaustion, ignored update, then exactly 64 more words with address wrap
        do_reset();
        configure(2, 7, 5);
        send(2, 128, 32'h2000_0000, 7, 5, 0);
        expect_block(2, 3);
        fs_pulse(10);
        expect_block(2, 2);
        vld = '0; vld[2] = 1'b1; fs_upd = 1'b1; fs_stream = 4'd2;
        #1;
        chk("ack_fs_cycle", 64'(ack), 64'(0));
        step();
        fs_upd = 1'b0;
        send(2, 64, 32'h2100_0000, 7, 5, 0);
        expect_block(2, 2);

        // Backpressure: packet held, no acks, release grants in the same cycle
        do_reset();
        configure(3, 1, 1);
        send(3, 1, 32'h0000_0033, 1, 1, 0);
        held = pkt(5'd1, 4'd1, 7'd0, 32'h0000_0033);
        out_ready = 1'b0;
        vld = '0; vld[3] = 1'b1; set_payload(3, 32'h0000_0044);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("ack_stall", 64'(ack), 64'(0));
            chk("dout_stall", 64'(dout), 64'(held));
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("ack_release", 64'(ack), 64'(1) << 3);
        exp_q.push_back(pkt(5'd1, 4'd1, 7'd1, 32'h0000_0044));
        step();
        vld = '0;
        send(3, 126, 32'h3400_0000, 1, 1, 2);
        expect_block(3, 2);

        // Grant and freespace return together at credit 1, then saturation from 100
        do_reset();
        configure(1, 2, 3);
        send(1, 127, 32'h5000_0000, 2, 3, 0);
        vld = '0; vld[1] = 1'b1; set_payload(1, 32'h5000_007F);
        fs_upd = 1'b1; fs_stream = 4'd1;
        #1;
        chk("ack_grant_fs", 64'(ack), 64'(1) << 1);
        exp_q.push_back(pkt(5'd2, 4'd3, 7'd127, 32'h5000_007F));
        step();
        fs_upd = 1'b0; vld = '0;
        send(1, 64, 32'h5100_0000, 2, 3, 0);
        expect_block(1, 2);
        fs_pulse(1);
        fs_pulse(1);
        send(1, 28, 32'h5200_0000, 2, 3, 64);
        fs_pulse(1);
        send(1, 128, 32'h5300_0000, 2, 3, 92);
        expect_block(1, 2);

        // Reset while a packet is held and valid is high
        do_reset();
        configure(4, 9, 6);
        send(4, 1, 32'h4444_0000, 9, 6, 0);
        out_ready = 1'b0; reset = 1'b1;
        vld = '0; vld[4] = 1'b1;
        #1;
        chk("ack_pre_reset", 64'(ack), 64'(0));
        step();
        chk("dout_after_reset", 64'(dout), 64'(0));
        chk("ack_after_reset", 64'(ack), 64'(0));
        exp_q.delete();
        reset = 1'b0; out_ready = 1'b1;
        vld = '1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ack_unconfigured", 64'(ack), 64'(0));
            step();
        end
        vld = '0;

        step();
        step();
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/leaf_out_packetizer.md
Name: leaf_out_packetizer

Overview:
- Output stage of a leaf shell, directly downstream of the user kernel's output streams (din_leaf_user2interface/vld/ack).
- Arbitrates the NUM_OUT_PORTS 32-bit user streams round-robin and stamps each accepted word with its configured destination leaf/port and a per-stream BRAM write address.
- Enforces per-stream credit (destination freespace) and emits one 49-bit BFT packet per cycle toward the BFT output register.

Parameters:
- PACKET_BITS, 49, packet width.
- PAYLOAD_BITS, 32, payload width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, write address field width.
- NUM_OUT_PORTS, 7, number of user output streams.
- FREESPACE_UPDATE_SIZE, 64, credits returned per freespace update.
- CREDIT_INIT, 128, per-stream credit after reset (= 2^NUM_ADDR_BITS, also the saturation maximum).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  payloads; stream i occupies bits [32i+31:32i].
- vld_user2interface  in  NUM_OUT_PORTS  per-stream valid.
- ack_interface2user  out  NUM_OUT_PORTS  per-stream accept (combinational).
- cfg_wr  in  1  configuration write strobe.
- cfg_stream  in  NUM_PORT_BITS  stream index to configure.
- cfg_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_port  in  NUM_PORT_BITS  destination port.
- fs_upd  in  1  freespace update strobe.
- fs_stream  in  NUM_PORT_BITS  stream receiving the update.
- dout_leaf_interface2bft  out  PACKET_BITS  packet.
- out_ready  in  1  downstream accepts the current packet.

Behaviour:
- Packet format:
  - [48] valid.
  - [47:43] dest leaf.
  - [42:39] dest port.
  - [38:32] write address.
  - [31:0] payload.
- Reset values:
  - dout = 0.
  - ack = 0.
  - All cfg_valid = 0, cfg_leaf = 0, cfg_port = 0.
  - Credits = CREDIT_INIT.
  - Address counters = 0.
  - RR pointer = 0.
- Reset mid-operation discards the held packet; any word already acked is lost, and this is by design.
- Stream i is eligible when vld[i], cfg_valid[i] and credit[i] != 0.
- slot_free = !dout[48] || out_ready.
- Grant (combinational): the first eligible stream at or after rr_ptr, wrapping from NUM_OUT_PORTS-1 to 0. Granting requires slot_free.
  - ack[i] = 1 only for the granted stream.
  - At most one ack is high per cycle.
  - ack is 0 for every stream whenever slot_free = 0.
- On a grant, at the next edge:
  - dout = {1, leaf[i], port[i], addr[i], payload[i]}; latency is one cycle.
  - addr[i] increments, wrapping 127 -> 0.
  - credit[i] decrements.
  - rr_ptr = i+1 (mod NUM_OUT_PORTS).
- No grant while slot_free:
  - dout[48] clears to 0; the other bits of dout are don't-care but are held.
  - rr_ptr is unchanged.
- slot_free = 0 (valid packet and !out_ready): dout holds every bit.
- fs_upd: credit[fs_stream] += FREESPACE_UPDATE_SIZE, saturating at CREDIT_INIT.
  - If the same stream is granted in the same cycle, the result is min(credit + 64 - 1, CREDIT_INIT).
- cfg_wr:
  - Writes leaf and port, and sets cfg_valid for cfg_stream.
  - Resets that stream's addr counter to 0.
  - Takes effect from the next cycle.
  - The stream is not eligible in the cfg_wr cycle itself.
- fs_stream or cfg_stream >= NUM_OUT_PORTS: the write or update is ignored.
- Credit width is NUM_ADDR_BITS+1 bits, so the value 128 is representable.

Decomposition:
- Shared package leaf_pkg holds:
  - Packet field offsets and widths (VALID_BIT, LEAF_MSB/LSB, PORT_MSB/LSB, ADDR_MSB/LSB).
  - CREDIT_INIT.
  - A packet struct typedef.
- One sub-module: rr_arbiter.
  - Parameterised by N.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
- Per-stream credit, address and config registers stay in the top block.

Test Plan:
- Configure stream 0 -> leaf 3, port 2; drive vld[0] with payload 0xDEADBEEF, out_ready = 1 -> ack[0] pulses; the next cycle dout = {1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}; the next word carries addr 1.
- Configure all 7 streams; hold vld = 7'h7F with out_ready = 1 -> grants follow the order 0, 1, 2, 3, 4, 5, 6, 0; no stream is granted twice within 7 cycles.
- Stream 2 alone sends 128 words with no fs_upd -> ack[2] stays 0 from word 129 on; one fs_upd(2) -> exactly 64 more words are accepted; the address wraps 127 -> 0 at word 129.
- Hold out_ready = 0 with a valid packet present for 5 cycles -> dout is stable, every ack = 0, and credits are unchanged; release -> the next grant occurs in the same cycle.
- Stream 1 credit = 1, with a grant and fs_upd(1) in the same cycle -> credit = 64; fs_upd at credit 100 -> credit = 128 (saturated).
- Assert reset while a packet is held and vld is high -> the next cycle dout = 0 and ack = 0; unconfigured streams get no ack despite vld.
